// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate with bias, ReLU and saturation.
// Latency: last accept in cycle t -> DRAIN t+1 -> FINISH t+2 -> out_valid from t+3; one activation/cycle.
// Backpressure: in_ready drops outside ACCUM; out_data holds while out_valid && !out_ready.
// Ports: clk/rst (async active-high); in_valid/in_data/in_ready activation stream;
//        bias (sampled in FINISH); weight_rd_en/addr/data to a 1-cycle-latency weight memory;
//        out_valid/out_data/out_ready result handshake; busy = frame or product in flight.
module neuron_mac #(
  parameter int NUM_INPUTS = 5,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  weight_rd_en,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr,
  input  logic [DATA_WIDTH-1:0] weight_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {ACCUM, DRAIN, FINISH, OUT} state_t;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [DATA_WIDTH-1:0] act_q;
  logic                         pend_q;
  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic [ADDR_WIDTH-1:0]        addr_q;

  logic                         accept;
  logic [ADDR_WIDTH-1:0]        addr_d;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0]  res_r;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic [DATA_WIDTH-1:0]        out_data_d;

  // Accepts are blocked while reset is held so no read escapes during reset.
  assign in_ready       = (state_q == ACCUM) && !rst;
  assign accept         = in_valid && in_ready;
  assign addr_d         = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
  assign weight_rd_en   = accept;
  assign weight_rd_addr = accept ? addr_d : addr_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign busy           = !((state_q == ACCUM) && (idx_q == '0) && !pend_q);

  // Product of the activation registered on the previous accept and the weight
  // the memory returns this cycle; both operands signed, full-width result.
  assign prod     = act_q * $signed(weight_rd_data);
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign acc_d    = pend_q ? (acc_q + prod_ext) : acc_q;

  // Bias is aligned to the product's 2*FRAC_BITS fraction before adding, then the
  // sum is shifted back to FRAC_BITS (floor) and clamped into [0, max positive].
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign sum_s    = acc_q + (bias_ext <<< FRAC_BITS);
  assign res_r    = sum_s >>> FRAC_BITS;

  always_comb begin
    out_data_d = res_r[DATA_WIDTH-1:0];
    if (res_r < 0) begin
      out_data_d = '0;
    end else if (res_r > SAT_MAX) begin
      out_data_d = SAT_MAX[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      act_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= ADDR_WIDTH'(BASE_ADDR);
    end else begin
      acc_q  <= acc_d;
      pend_q <= accept;
      if (accept) begin
        act_q  <= in_data;
        addr_q <= addr_d;
      end
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
              idx_q   <= '0;
              state_q <= DRAIN;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          state_q <= FINISH;
        end
        FINISH: begin
          out_valid_q <= 1'b1;
          out_data_q  <= out_data_d;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule
